// File: rtl/register_bank_if.sv
//------------------------------------------------------------------------------
// Module  : register_bank_if
// Brief   : Bus bundle between the issue/writeback logic and register_bank.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface register_bank_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
);

  // write / reserve side
  logic              regWrite;
  logic [ADDR_W-1:0] writeRegister;
  logic [WIDTH-1:0]  writeData;
  logic              reserve;
  logic [ADDR_W-1:0] reserveRegister;

  // read side
  logic [ADDR_W-1:0] register1;
  logic [ADDR_W-1:0] register2;
  logic [WIDTH-1:0]  readData1;
  logic [WIDTH-1:0]  readData2;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W:0]   pendingCount;

  modport master (
    output regWrite,
    output writeRegister,
    output writeData,
    output reserve,
    output reserveRegister,
    output register1,
    output register2,
    input  readData1,
    input  readData2,
    input  busy1,
    input  busy2,
    input  pendingCount
  );

  modport slave (
    input  regWrite,
    input  writeRegister,
    input  writeData,
    input  reserve,
    input  reserveRegister,
    input  register1,
    input  register2,
    output readData1,
    output readData2,
    output busy1,
    output busy2,
    output pendingCount
  );

endinterface

`default_nettype wire

// File: rtl/register_bank.sv
//------------------------------------------------------------------------------
// Module  : register_bank
// Brief   : Two-read / one-write register file with per-register pending
//           (scoreboard) bits and a registered pending population count.
//           Define REGISTER_BANK_BYPASS_EN to forward same-cycle writes to reads.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_bank #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic      clock,
  input  wire logic      reset,
  register_bank_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_ZERO_IDX = '0;

  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [ADDR_W:0]   r_count;

  logic              w_wr_en;
  logic              w_rsv_en;
  logic [DEPTH-1:0]  w_pending_nxt;
  logic [ADDR_W:0]   w_count_nxt;

  logic [WIDTH-1:0]  w_rd1;
  logic [WIDTH-1:0]  w_rd2;
  logic              w_busy1;
  logic              w_busy2;

  // Index 0 is hardwired: never written, never reserved.
  assign w_wr_en  = bus.regWrite && (bus.writeRegister   != c_ZERO_IDX);
  assign w_rsv_en = bus.reserve  && (bus.reserveRegister != c_ZERO_IDX);

  // Write clears, reserve sets; reserve is applied last so it wins on a tie.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr_en) begin
      w_pending_nxt[bus.writeRegister] = 1'b0;
    end
    if (w_rsv_en) begin
      w_pending_nxt[bus.reserveRegister] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + {{ADDR_W{1'b0}}, w_pending_nxt[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.writeRegister] <= bus.writeData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Read ports: stored state first, then optional same-cycle forwarding.
  always_comb begin
    w_rd1   = (bus.register1 == c_ZERO_IDX) ? '0 : r_regs[bus.register1];
    w_rd2   = (bus.register2 == c_ZERO_IDX) ? '0 : r_regs[bus.register2];
    w_busy1 = (bus.register1 != c_ZERO_IDX) && r_pending[bus.register1];
    w_busy2 = (bus.register2 != c_ZERO_IDX) && r_pending[bus.register2];
`ifdef REGISTER_BANK_BYPASS_EN
    if (w_wr_en && (bus.writeRegister == bus.register1)) begin
      w_rd1   = bus.writeData;
      w_busy1 = w_rsv_en && (bus.reserveRegister == bus.register1);
    end
    if (w_wr_en && (bus.writeRegister == bus.register2)) begin
      w_rd2   = bus.writeData;
      w_busy2 = w_rsv_en && (bus.reserveRegister == bus.register2);
    end
`else
    // Without forwarding, a write becomes visible the cycle after its edge.
`endif
  end

  // Reset masks the outputs so forwarding cannot leak writeData through.
  assign bus.readData1    = reset ? '0   : w_rd1;
  assign bus.readData2    = reset ? '0   : w_rd2;
  assign bus.busy1        = reset ? 1'b0 : w_busy1;
  assign bus.busy2        = reset ? 1'b0 : w_busy2;
  assign bus.pendingCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_register_bank.sv
//------------------------------------------------------------------------------
// Module  : tb_register_bank
// Brief   : Directed self-checking bench for register_bank.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_bank;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  register_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.regWrite        = 1'b0;
    bus.writeRegister   = '0;
    bus.writeData       = '0;
    bus.reserve         = 1'b0;
    bus.reserveRegister = '0;
    bus.register1       = '0;
    bus.register2       = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.regWrite      = 1'b1;
    bus.writeRegister = 5'd5;
    bus.writeData     = 32'hFFFF_FFFF;
    bus.register1     = 5'd5;
    bus.reserve       = 1'b1;
    bus.reserveRegister = 5'd5;
    tick();
    n_vec++;
    if (bus.pendingCount !== 6'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", bus.pendingCount);
    end
    n_vec++;
    if (bus.readData1 !== 32'h0) begin
      n_err++; $display("FAIL reset_rd1: got %h want 0", bus.readData1);
    end
    n_vec++;
    if (bus.busy1 !== 1'b0) begin
      n_err++; $display("FAIL reset_busy1: got %b want 0", bus.busy1);
    end
    idle();
    reset = 1'b0;
    #1;
    bus.register1 = 5'd5;
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0) begin
      n_err++; $display("FAIL reset_wr_ignored: got %h want 0", bus.readData1);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    bus.regWrite      = 1'b1;
    bus.writeRegister = 5'd5;
    bus.writeData     = 32'hDEAD_BEEF;
    tick();
    idle();
    bus.register1 = 5'd5;
    #1;
    n_vec++;
    if (bus.readData1 !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL wr_r5: got %h want deadbeef", bus.readData1);
    end
    bus.regWrite      = 1'b1;
    bus.writeRegister = 5'd0;
    bus.writeData     = 32'h0000_1234;
    tick();
    idle();
    bus.register2 = 5'd0;
    #1;
    n_vec++;
    if (bus.readData2 !== 32'h0) begin
      n_err++; $display("FAIL wr_r0: got %h want 0", bus.readData2);
    end
    bus.reserve         = 1'b1;
    bus.reserveRegister = 5'd0;
    tick();
    idle();
    n_vec++;
    if (bus.pendingCount !== 6'd0 || bus.busy2 !== 1'b0) begin
      n_err++; $display("FAIL rsv_r0: got count %0d busy %b want 0 0", bus.pendingCount, bus.busy2);
    end
  endtask

  task automatic test_reserve();
    do_reset();
    bus.reserve         = 1'b1;
    bus.reserveRegister = 5'd7;
    tick();
    n_vec++;
    if (bus.pendingCount !== 6'd1) begin
      n_err++; $display("FAIL rsv_cnt1: got %0d want 1", bus.pendingCount);
    end
    bus.reserveRegister = 5'd9;
    tick();
    idle();
    bus.register1 = 5'd7;
    bus.register2 = 5'd9;
    #1;
    n_vec++;
    if (bus.pendingCount !== 6'd2) begin
      n_err++; $display("FAIL rsv_cnt2: got %0d want 2", bus.pendingCount);
    end
    n_vec++;
    if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin
      n_err++; $display("FAIL rsv_busy: got %b%b want 11", bus.busy1, bus.busy2);
    end
    bus.regWrite      = 1'b1;
    bus.writeRegister = 5'd7;
    bus.writeData     = 32'h0000_00A5;
    tick();
    bus.regWrite = 1'b0;
    #1;
    n_vec++;
    if (bus.busy1 !== 1'b0 || bus.pendingCount !== 6'd1 || bus.readData1 !== 32'hA5) begin
      n_err++; $display("FAIL wr_clears: got busy %b cnt %0d data %h want 0 1 a5",
                        bus.busy1, bus.pendingCount, bus.readData1);
    end
  endtask

  task automatic test_reserve_write_same();
    do_reset();
    bus.regWrite        = 1'b1;
    bus.writeRegister   = 5'd3;
    bus.writeData       = 32'h55;
    bus.reserve         = 1'b1;
    bus.reserveRegister = 5'd3;
    tick();
    idle();
    bus.register1 = 5'd3;
    bus.register2 = 5'd3;
    #1;
    n_vec++;
    if (bus.readData2 !== 32'h55 || bus.busy2 !== 1'b1 || bus.pendingCount !== 6'd1) begin
      n_err++; $display("FAIL rsv_wins: got data %h busy %b cnt %0d want 55 1 1",
                        bus.readData2, bus.busy2, bus.pendingCount);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
    logic        exp_busy;
    do_reset();
    bus.regWrite      = 1'b1;
    bus.writeRegister = 5'd4;
    bus.writeData     = 32'h77;
    bus.register1     = 5'd4;
    #1;
`ifdef REGISTER_BANK_BYPASS_EN
    exp_rd = 32'h77;
`else
    exp_rd = 32'h0;
`endif
    n_vec++;
    if (bus.readData1 !== exp_rd || bus.busy1 !== 1'b0) begin
      n_err++; $display("FAIL bypass_rd: got %h busy %b want %h 0", bus.readData1, bus.busy1, exp_rd);
    end
    tick();
    idle();
    bus.register1 = 5'd4;
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h77) begin
      n_err++; $display("FAIL after_wr_r4: got %h want 77", bus.readData1);
    end
    // Write plus reserve to the port-2 index while it is not yet pending.
    bus.regWrite        = 1'b1;
    bus.writeRegister   = 5'd12;
    bus.writeData       = 32'h1200;
    bus.reserve         = 1'b1;
    bus.reserveRegister = 5'd12;
    bus.register2       = 5'd12;
    #1;
`ifdef REGISTER_BANK_BYPASS_EN
    exp_rd = 32'h1200; exp_busy = 1'b1;
`else
    exp_rd = 32'h0;    exp_busy = 1'b0;
`endif
    n_vec++;
    if (bus.readData2 !== exp_rd || bus.busy2 !== exp_busy) begin
      n_err++; $display("FAIL bypass_rsv: got %h busy %b want %h %b",
                        bus.readData2, bus.busy2, exp_rd, exp_busy);
    end
    tick();
    idle();
  endtask

  task automatic test_reserve_all_reset();
    do_reset();
    bus.regWrite      = 1'b1;
    bus.writeRegister = 5'd6;
    bus.writeData     = 32'h1111_2222;
    tick();
    idle();
    for (int i = 1; i < DEPTH; i++) begin
      bus.reserve         = 1'b1;
      bus.reserveRegister = i[ADDR_W-1:0];
      tick();
    end
    idle();
    bus.register1 = 5'd6;
    bus.register2 = 5'd31;
    #1;
    n_vec++;
    if (bus.pendingCount !== 6'd31) begin
      n_err++; $display("FAIL all_cnt: got %0d want 31", bus.pendingCount);
    end
    n_vec++;
    if (bus.readData1 !== 32'h1111_2222 || bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin
      n_err++; $display("FAIL all_state: got %h %b %b want 11112222 1 1",
                        bus.readData1, bus.busy1, bus.busy2);
    end
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0 ||
        bus.pendingCount !== 6'd0) begin
      n_err++; $display("FAIL async_rst: got %h %b %b %0d want 0 0 0 0",
                        bus.readData1, bus.busy1, bus.busy2, bus.pendingCount);
    end
    #2 reset = 1'b0;
    #1;
    bus.reserve         = 1'b1;
    bus.reserveRegister = 5'd2;
    bus.register1       = 5'd2;
    tick();
    bus.reserve = 1'b0;
    #1;
    n_vec++;
    if (bus.pendingCount !== 6'd1 || bus.busy1 !== 1'b1) begin
      n_err++; $display("FAIL post_rst: got cnt %0d busy %b want 1 1", bus.pendingCount, bus.busy1);
    end
    idle();
  endtask

  task automatic test_double_reserve();
    do_reset();
    bus.reserve         = 1'b1;
    bus.reserveRegister = 5'd2;
    tick();
    tick();
    idle();
    n_vec++;
    if (bus.pendingCount !== 6'd1) begin
      n_err++; $display("FAIL dbl_rsv: got %0d want 1", bus.pendingCount);
    end
    bus.regWrite      = 1'b1;
    bus.writeRegister = 5'd8;
    bus.writeData     = 32'h8888;
    tick();
    idle();
    bus.register1 = 5'd8;
    bus.register2 = 5'd2;
    #1;
    n_vec++;
    if (bus.pendingCount !== 6'd1 || bus.readData1 !== 32'h8888 || bus.busy1 !== 1'b0 ||
        bus.busy2 !== 1'b1) begin
      n_err++; $display("FAIL wr_nonpend: got cnt %0d data %h busy %b%b want 1 8888 01",
                        bus.pendingCount, bus.readData1, bus.busy1, bus.busy2);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_reserve();
    test_reserve_write_same();
    test_bypass();
    test_reserve_all_reset();
    test_double_reserve();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register in bits.
REQ-002 Parameter DEPTH, default 32: number of registers, power of two, minimum 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): register index width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 regWrite  input  1  write enable from Control.
REQ-008 register1  input  ADDR_W  read port 1 index.
REQ-009 register2  input  ADDR_W  read port 2 index.
REQ-010 writeRegister  input  ADDR_W  write port index.
REQ-011 writeData  input  WIDTH  data to write.
REQ-012 reserve  input  1  marks reserveRegister pending (destination of an issued instruction).
REQ-013 reserveRegister  input  ADDR_W  index to mark pending.
REQ-014 readData1  output  WIDTH  contents of register1.
REQ-015 readData2  output  WIDTH  contents of register2.
REQ-016 busy1  output  1  register1 has a pending write.
REQ-017 busy2  output  1  register2 has a pending write.
REQ-018 pendingCount  output  ADDR_W+1  number of registers currently pending.

Function
REQ-019 Reads SHALL be combinational: readDataN = register[registerN], zero latency.
REQ-020 Register 0 SHALL always read 0; writes and reserves to index 0 SHALL be ignored.
REQ-021 On a rising clock with regWrite=1 and writeRegister!=0, register[writeRegister] SHALL take writeData.
REQ-022 Each register SHALL have a pending bit; reserve=1 with reserveRegister!=0 SHALL set it at the clock edge.
REQ-023 regWrite=1 to a register SHALL clear its pending bit at the same edge.
REQ-024 Simultaneous reserve and write to the same index: data SHALL be written and the pending bit SHALL remain/become set (reserve wins).
REQ-025 Reserve of an already-pending register SHALL leave it pending; pendingCount SHALL not change.
REQ-026 Write to a non-pending register SHALL update data; pendingCount SHALL not change.
REQ-027 busyN SHALL equal the pending bit of registerN (combinational); busyN for index 0 SHALL be 0.
REQ-028 pendingCount SHALL be registered and updated at each edge to equal the population count of pending bits after that edge; range 0..DEPTH-1.
REQ-029 Indices are unsigned; no out-of-range index exists since DEPTH=2^ADDR_W.

Reset
REQ-030 reset=1 SHALL immediately clear all registers to 0, all pending bits to 0 and pendingCount to 0, independent of clock.
REQ-031 While reset=1, regWrite and reserve SHALL have no effect; readData1/2, busy1/2 SHALL read 0.
REQ-032 Reset asserted mid-sequence SHALL discard all pending reservations; the first edge after deassertion SHALL operate normally.

Configuration
REQ-033 Macro REGISTER_BANK_BYPASS_EN SHALL control write-to-read forwarding.
REQ-034 Defined: when regWrite=1 and writeRegister==registerN!=0, readDataN SHALL equal writeData and busyN SHALL be 0 in that same cycle (unless reserve targets the same index, then busyN=1).
REQ-035 Not defined: readDataN and busyN SHALL show pre-edge state; new value visible the cycle after the write.

Verification
REQ-036 Reset, write 0xDEADBEEF to r5, read r5 on port 1 next cycle -> readData1=0xDEADBEEF; write 0x1234 to r0 -> readData2(r0)=0.
REQ-037 Reserve r7, then r9 -> pendingCount 1 then 2, busy1(r7)=1; write r7=0xA5 -> busy1=0, pendingCount=1, readData1=0xA5.
REQ-038 Same cycle reserve r3 and write r3=0x55 -> next cycle readData=0x55, busy=1, pendingCount=1.
REQ-039 Write r4=0x77 with register1=r4 same cycle -> readData1=0x77 in that cycle with REGISTER_BANK_BYPASS_EN, old value 0 without.
REQ-040 Reserve r1..r31 (31 cycles) -> pendingCount=31; assert reset between edges -> all outputs 0 immediately, pendingCount=0.
REQ-041 Reserve r2 twice, write r8 (not pending) -> pendingCount stays 1, r8 data updated.
